// File: rtl/scene_sequencer.sv
// Frame-level scene scheduler: fires one tick per frame on the first blanking line
// and walks each scene through FADE_IN -> SHOW -> FADE_OUT on those ticks.
module scene_sequencer #(
  parameter int NUM_SCENES   = 4,
  parameter int SCENE_FRAMES = 240,
  parameter int FRAME_LINE   = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        pause,
  input  logic        skip,
  output logic        frame_tick,
  output logic [15:0] frame_count,
  output logic [3:0]  scene,
  output logic [7:0]  scene_frame,
  output logic [3:0]  fade,
  output logic [1:0]  phase
);

  typedef enum logic [1:0] {
    FADE_IN  = 2'd0,
    SHOW     = 2'd1,
    FADE_OUT = 2'd2
  } state_t;

  localparam logic [3:0] LAST_SCENE = 4'(NUM_SCENES - 1);
  localparam logic [7:0] LAST_FRAME = 8'(SCENE_FRAMES - 1);
  localparam logic [9:0] TICK_LINE  = 10'(FRAME_LINE);

  state_t state;
  logic   skip_prev;
  logic   skip_pending;
  logic   tick_cond;
  logic   skip_edge;

  assign tick_cond = (hpos == 10'd0) && (vpos == TICK_LINE);
  assign skip_edge = skip && !skip_prev;
  assign phase     = state;

  // A skip edge landing on an unpaused tick survives the clear and is served next tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FADE_IN;
      frame_tick   <= 1'b0;
      frame_count  <= 16'd0;
      scene        <= 4'd0;
      scene_frame  <= 8'd0;
      fade         <= 4'd0;
      skip_prev    <= 1'b0;
      skip_pending <= 1'b0;
    end else begin
      frame_tick <= tick_cond;
      skip_prev  <= skip;
      if (!tick_cond || pause) begin
        skip_pending <= skip_pending | skip_edge;
      end
      if (tick_cond) begin
        frame_count <= frame_count + 16'd1;
        if (!pause) begin
          skip_pending <= skip_edge;
          case (state)
            FADE_IN: begin
              if (skip_pending) begin
                state <= FADE_OUT;
              end else begin
                fade <= fade + 4'd1;
                if (fade == 4'd14) begin
                  state       <= SHOW;
                  scene_frame <= 8'd0;
                end
              end
            end
            SHOW: begin
              if (skip_pending || scene_frame == LAST_FRAME) begin
                state <= FADE_OUT;
              end else begin
                scene_frame <= scene_frame + 8'd1;
              end
            end
            FADE_OUT: begin
              // fade==0 here only when a skip was taken from a black FADE_IN.
              if (fade <= 4'd1) begin
                fade  <= 4'd0;
                state <= FADE_IN;
                scene <= (scene == LAST_SCENE) ? 4'd0 : scene + 4'd1;
              end else begin
                fade <= fade - 4'd1;
              end
            end
            default: state <= FADE_IN;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_scene_sequencer.sv
// Bench for scene_sequencer: behavioural model feeding a scoreboard queue, a
// table of tick-decode vectors, and hand-written multi-cycle sequences.
module tb_scene_sequencer;

  localparam int NS = 2;
  localparam int SF = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  hpos = 10'd0;
  logic [9:0]  vpos = 10'd0;
  logic        pause = 1'b0;
  logic        skip = 1'b0;
  logic        frame_tick;
  logic [15:0] frame_count;
  logic [3:0]  scene;
  logic [7:0]  scene_frame;
  logic [3:0]  fade;
  logic [1:0]  phase;

  scene_sequencer #(
    .NUM_SCENES(NS),
    .SCENE_FRAMES(SF),
    .FRAME_LINE(480)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hpos(hpos),
    .vpos(vpos),
    .pause(pause),
    .skip(skip),
    .frame_tick(frame_tick),
    .frame_count(frame_count),
    .scene(scene),
    .scene_frame(scene_frame),
    .fade(fade),
    .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tick;
    logic [15:0] count;
    logic [3:0]  scene;
    logic [7:0]  sf;
    logic [3:0]  fade;
    logic [1:0]  phase;
  } exp_t;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       exp_tick;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   tick_seen = 0;
  logic cur_pause = 1'b0;

  // Reference model state
  int   m_count, m_scene, m_sf, m_fade, m_phase;
  logic m_tick, m_skip, m_skip_prev;

  task automatic model_step(input logic [9:0] h, input logic [9:0] v,
                            input logic p, input logic s, input logic r);
    logic is_tick;
    logic rise;
    is_tick = (h == 10'd0) && (v == 10'd480);
    rise    = s && !m_skip_prev;
    if (r) begin
      m_count = 0; m_scene = 0; m_sf = 0; m_fade = 0; m_phase = 0;
      m_tick = 0; m_skip = 0; m_skip_prev = 0;
      return;
    end
    m_tick      = is_tick;
    m_skip_prev = s;
    if (is_tick && !p) begin
      m_count = (m_count + 1) % 65536;
      if (m_phase == 0) begin
        if (m_skip) m_phase = 2;
        else begin
          m_fade = m_fade + 1;
          if (m_fade == 15) begin m_phase = 1; m_sf = 0; end
        end
      end else if (m_phase == 1) begin
        if (m_skip || m_sf == SF - 1) m_phase = 2;
        else m_sf = m_sf + 1;
      end else begin
        m_fade = (m_fade > 0) ? m_fade - 1 : 0;
        if (m_fade == 0) begin
          m_phase = 0;
          m_scene = (m_scene + 1) % NS;
        end
      end
      m_skip = rise;
    end else begin
      if (is_tick) m_count = (m_count + 1) % 65536;
      m_skip = m_skip | rise;
    end
  endtask

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output(input exp_t e);
    check_val("sb_frame_tick", {15'd0, frame_tick}, {15'd0, e.tick});
    check_val("sb_frame_count", frame_count, e.count);
    check_val("sb_scene", {12'd0, scene}, {12'd0, e.scene});
    check_val("sb_scene_frame", {8'd0, scene_frame}, {8'd0, e.sf});
    check_val("sb_fade", {12'd0, fade}, {12'd0, e.fade});
    check_val("sb_phase", {14'd0, phase}, {14'd0, e.phase});
  endtask

  task automatic apply_stimulus(input logic [9:0] h, input logic [9:0] v, input logic p,
                                input logic s, input logic r, input bit chk = 1'b1);
    exp_t e;
    hpos = h; vpos = v; pause = p; skip = s; reset = r;
    model_step(h, v, p, s, r);
    if (chk) begin
      e.tick  = m_tick;
      e.count = 16'(m_count);
      e.scene = 4'(m_scene);
      e.sf    = 8'(m_sf);
      e.fade  = 4'(m_fade);
      e.phase = 2'(m_phase);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (frame_tick === 1'b1) tick_seen++;
    if (chk) check_output(sb_q.pop_front());
  endtask

  task automatic do_tick();
    apply_stimulus(10'd0, 10'd480, cur_pause, 1'b0, 1'b0);
    apply_stimulus(10'd7, 10'd100, cur_pause, 1'b0, 1'b0);
  endtask

  task automatic skip_pulse();
    apply_stimulus(10'd3, 10'd200, cur_pause, 1'b1, 1'b0);
    apply_stimulus(10'd3, 10'd200, cur_pause, 1'b0, 1'b0);
  endtask

  task automatic expect_state(input string tag, input int ph, input int fd, input int sc);
    check_val({tag, "_phase"}, {14'd0, phase}, 16'(ph));
    check_val({tag, "_fade"}, {12'd0, fade}, 16'(fd));
    check_val({tag, "_scene"}, {12'd0, scene}, 16'(sc));
  endtask

  vec_t vecs[8];
  int   fc_before;

  initial begin
    vecs[0] = '{10'd0,    10'd479, 1'b0};
    vecs[1] = '{10'd0,    10'd481, 1'b0};
    vecs[2] = '{10'd1,    10'd480, 1'b0};
    vecs[3] = '{10'd639,  10'd480, 1'b0};
    vecs[4] = '{10'd0,    10'd0,   1'b0};
    vecs[5] = '{10'd0,    10'd480, 1'b1};
    vecs[6] = '{10'd1023, 10'd480, 1'b0};
    vecs[7] = '{10'd0,    10'd992, 1'b0};

    apply_stimulus(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    check_val("reset_count", frame_count, 16'd0);
    check_val("reset_tick", {15'd0, frame_tick}, 16'd0);
    expect_state("reset", 0, 0, 0);

    $display("[TB] fade-in ramp");
    tick_seen = 0;
    for (int i = 1; i <= 15; i++) begin
      do_tick();
      check_val("ramp_fade", {12'd0, fade}, 16'(i));
    end
    check_val("ramp_phase", {14'd0, phase}, 16'd1);
    check_val("ramp_sf", {8'd0, scene_frame}, 16'd0);
    check_val("ramp_tick_pulses", 16'(tick_seen), 16'd15);

    $display("[TB] full scene and wrap");
    for (int i = 16; i <= 18; i++) do_tick();
    check_val("show_last_sf", {8'd0, scene_frame}, 16'd3);
    check_val("show_last_phase", {14'd0, phase}, 16'd1);
    do_tick();
    expect_state("show_end", 2, 15, 0);
    for (int i = 20; i <= 34; i++) do_tick();
    expect_state("scene_end", 0, 0, 1);
    for (int i = 0; i < 34; i++) do_tick();
    expect_state("scene_wrap", 0, 0, 0);

    $display("[TB] skip in SHOW and in FADE_OUT");
    for (int i = 0; i < 16; i++) do_tick();
    check_val("pre_skip_sf", {8'd0, scene_frame}, 16'd1);
    skip_pulse();
    do_tick();
    expect_state("skip_show", 2, 15, 0);
    check_val("skip_sf_hold", {8'd0, scene_frame}, 16'd1);
    skip_pulse();
    for (int i = 0; i < 14; i++) do_tick();
    expect_state("fo_ignore_skip", 2, 1, 0);
    do_tick();
    expect_state("fo_done", 0, 0, 1);

    $display("[TB] pause");
    for (int i = 0; i < 3; i++) do_tick();
    fc_before = int'(frame_count);
    cur_pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_tick();
      if (i == 4) skip_pulse();
    end
    check_val("pause_count", frame_count, 16'(fc_before + 10));
    expect_state("pause_hold", 0, 3, 1);
    cur_pause = 1'b0;
    do_tick();
    expect_state("pause_skip_applied", 2, 3, 1);
    for (int i = 0; i < 3; i++) do_tick();
    expect_state("pause_scene_end", 0, 0, 0);

    $display("[TB] skip at fade 0");
    skip_pulse();
    do_tick();
    expect_state("fade0_skip", 2, 0, 0);
    do_tick();
    expect_state("fade0_advance", 0, 0, 1);

    $display("[TB] skip edge coincident with tick");
    apply_stimulus(10'd0, 10'd480, 1'b0, 1'b1, 1'b0);
    expect_state("coinc_tick", 0, 1, 1);
    apply_stimulus(10'd7, 10'd100, 1'b0, 1'b0, 1'b0);
    do_tick();
    expect_state("coinc_next", 2, 1, 1);
    do_tick();
    expect_state("coinc_end", 0, 0, 0);

    $display("[TB] reset mid FADE_OUT");
    for (int i = 0; i < 5; i++) do_tick();
    skip_pulse();
    do_tick();
    do_tick();
    expect_state("pre_reset", 2, 4, 0);
    skip_pulse();
    apply_stimulus(10'd9, 10'd300, 1'b0, 1'b0, 1'b1);
    expect_state("mid_reset", 0, 0, 0);
    check_val("mid_reset_count", frame_count, 16'd0);
    check_val("mid_reset_sf", {8'd0, scene_frame}, 16'd0);
    apply_stimulus(10'd9, 10'd300, 1'b0, 1'b0, 1'b0);
    do_tick();
    expect_state("post_reset_no_skip", 0, 1, 0);

    $display("[TB] tick decode vectors");
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].h, vecs[i].v, 1'b0, 1'b0, 1'b0);
      check_val("tick_vec", {15'd0, frame_tick}, {15'd0, vecs[i].exp_tick});
      apply_stimulus(10'd5, 10'd5, 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] frame_count wrap");
    apply_stimulus(10'd0, 10'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 65535; i++) apply_stimulus(10'd0, 10'd480, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("count_ffff", frame_count, 16'hFFFF);
    apply_stimulus(10'd0, 10'd480, 1'b1, 1'b0, 1'b0);
    check_val("count_wrap", frame_count, 16'h0000);
    check_val("wrap_tick", {15'd0, frame_tick}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
